// File: rtl/remote_comm_pkg.sv
// rtl/remote_comm_pkg.sv - shared types and constants for the remote_comm UART command bridge
package remote_comm_pkg;

  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} cmd_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rx_state_t;

  localparam int         UART_FRAME_BITS = 10;
  localparam logic [7:0] RESP_CAL_DONE   = 8'hA5;

endpackage

// File: rtl/remote_comm_uart_trx.sv
// rtl/remote_comm_uart_trx.sv - independent 8N1 UART transmitter and receiver (BAUD_DIV clocks per bit)
module uart_trx
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  logic [UART_FRAME_BITS-1:0] tx_shft;
  logic [CW-1:0]              tx_cnt;
  logic [3:0]                 tx_bits;
  logic                       tx_busy;

  // Shift register refills with ones, so its LSB is the idle-high line level.
  assign TX = tx_shft[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft <= '1;
      tx_cnt  <= '0;
      tx_bits <= '0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (trmt) begin
        tx_shft <= {1'b1, tx_data, 1'b0};
        tx_cnt  <= '0;
        tx_bits <= '0;
        tx_busy <= 1'b1;
      end else if (tx_busy) begin
        if (tx_cnt == BAUD_LAST) begin
          tx_cnt  <= '0;
          tx_shft <= {1'b1, tx_shft[UART_FRAME_BITS-1:1]};
          tx_bits <= tx_bits + 4'd1;
          if (tx_bits == 4'(UART_FRAME_BITS - 1)) begin
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

  logic          rx_ff1, rx_sync, rx_prev;
  rx_state_t     rx_state, rx_nxt;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bits;
  logic [7:0]    rx_shft;
  logic          baud_hit;

  assign rx_data  = rx_shft;
  assign baud_hit = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BAUD_LAST);

  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_nxt = RX_START;
      RX_START: if (baud_hit) rx_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (baud_hit && rx_bits == 4'd8) rx_nxt = RX_IDLE;
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1   <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shft  <= '0;
      rx_rdy   <= 1'b0;
    end else begin
      rx_ff1   <= RX;
      rx_sync  <= rx_ff1;
      rx_prev  <= rx_sync;
      rx_state <= rx_nxt;
      rx_rdy   <= 1'b0;
      if (rx_state == RX_IDLE || baud_hit) rx_cnt <= '0;
      else                                 rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START) rx_bits <= '0;
      // Ninth sample is the stop bit: deliver the byte without checking it.
      if (rx_state == RX_DATA && baud_hit) begin
        if (rx_bits == 4'd8) begin
          rx_rdy <= 1'b1;
        end else begin
          rx_shft <= {rx_sync, rx_shft[7:1]};
          rx_bits <= rx_bits + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - two-byte command sender and response receiver; REMOTE_COMM_STICKY_SNT_EN makes cmd_snt a level
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  cmd_state_t state, nxt;
  logic [7:0] cmd_lo;
  logic       trmt, tx_done, rx_rdy, accept, lo_done;
  logic [7:0] tx_data, rx_data;

  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .TX      (TX),
    .trmt    (trmt),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .rx_rdy  (rx_rdy),
    .rx_data (rx_data)
  );

  // High byte goes straight from the cmd port; only the low byte must be held.
  always_comb begin
    nxt     = state;
    trmt    = 1'b0;
    tx_data = cmd[15:8];
    accept  = 1'b0;
    lo_done = 1'b0;
    case (state)
      IDLE: if (snd_cmd) begin
        accept = 1'b1;
        trmt   = 1'b1;
        nxt    = SEND_HI;
      end
      SEND_HI: begin
        tx_data = cmd_lo;
        if (tx_done) begin
          trmt = 1'b1;
          nxt  = SEND_LO;
        end
      end
      SEND_LO: if (tx_done) begin
        lo_done = 1'b1;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cmd_lo   <= '0;
      cmd_snt  <= 1'b0;
      resp_rdy <= 1'b0;
      resp     <= '0;
    end else begin
      state    <= nxt;
      resp_rdy <= rx_rdy;
      if (accept) cmd_lo <= cmd[7:0];
      if (rx_rdy) resp <= rx_data;
`ifdef REMOTE_COMM_STICKY_SNT_EN
      if (accept)       cmd_snt <= 1'b0;
      else if (lo_done) cmd_snt <= 1'b1;
`else
      cmd_snt <= lo_done;
`endif
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// tb/tb_remote_comm.sv - scoreboard bench for remote_comm (TX frames decoded, RX bytes driven by a model UART)
module tb_remote_comm;
  import remote_comm_pkg::*;

  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd = '0;
  logic        snd_cmd = 1'b0;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  int          n_chk = 0;
  int          n_fail = 0;
  int          snt_cycles = 0;
  int          rdy_pulses = 0;
  logic        rdy_prev = 1'b0;
  logic        rst_seen = 1'b0;
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .TX       (TX),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .cmd_snt  (cmd_snt),
    .resp_rdy (resp_rdy),
    .resp     (resp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge rst_n) rst_seen = 1'b1;

  always @(negedge clk) begin
    if (cmd_snt) snt_cycles++;
    if (rdy_prev) check_eq("resp_rdy_one_cycle", resp_rdy, 0);
    if (resp_rdy) begin
      rdy_pulses++;
      check_eq("rx_queue_nonempty", rx_q.size() != 0, 1);
      if (rx_q.size() != 0) check_eq("resp_byte", resp, rx_q.pop_front());
    end
    rdy_prev = resp_rdy;
  end

  // Decodes every TX frame at mid-bit; frames cut by reset are dropped.
  initial begin : tx_mon
    logic       prev;
    logic       st, sp;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !TX && rst_n) begin
        rst_seen = 1'b0;
        repeat (B / 2) @(negedge clk);
        st = TX;
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = TX;
        end
        repeat (B) @(negedge clk);
        sp = TX;
        if (!rst_seen) begin
          check_eq("tx_start_bit", st, 0);
          check_eq("tx_stop_bit", sp, 1);
          check_eq("tx_frame_expected", tx_q.size() != 0, 1);
          if (tx_q.size() != 0) check_eq("tx_byte", b, tx_q.pop_front());
        end
      end
      prev = TX;
    end
  end

  task automatic send_cmd(input logic [15:0] c, output int lat);
    @(negedge clk);
    cmd = c;
    snd_cmd = 1'b1;
    tx_q.push_back(c[15:8]);
    tx_q.push_back(c[7:0]);
    @(negedge clk);
    snd_cmd = 1'b0;
    lat = 1;
    while (!cmd_snt && lat < 30 * B) begin
      @(negedge clk);
      lat++;
    end
    check_eq("cmd_snt_seen", cmd_snt, 1);
  endtask

  task automatic uart_send(input logic [7:0] d);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    rx_q.push_back(d);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      RX = f[i];
      repeat (B - 1) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, base, rbase;
    logic tx_low;

    repeat (3) @(negedge clk);
    check_eq("rst_tx", TX, 1);
    check_eq("rst_cmd_snt", cmd_snt, 0);
    check_eq("rst_resp_rdy", resp_rdy, 0);
    check_eq("rst_resp", resp, 8'h00);
    rst_n = 1'b1;
    tx_low = 1'b0;
    repeat (10 * B) begin
      @(negedge clk);
      if (!TX) tx_low = 1'b1;
    end
    check_eq("idle_tx_high", tx_low, 0);

    base = snt_cycles;
    send_cmd(16'h0000, lat);
    check_eq("latency_0000", (lat >= 20 * B + 2) && (lat <= 20 * B + 4), 1);
    repeat (3 * B) @(negedge clk);
    check_eq("snt_pulse_0000", snt_cycles - base, 1);
    check_eq("txq_drained_0000", tx_q.size(), 0);

    base = snt_cycles;
    send_cmd(16'h29C3, lat);
    check_eq("latency_29c3", (lat >= 20 * B + 2) && (lat <= 20 * B + 4), 1);
    repeat (3 * B) @(negedge clk);
    check_eq("snt_pulse_29c3", snt_cycles - base, 1);
    check_eq("txq_drained_29c3", tx_q.size(), 0);

    rbase = rdy_pulses;
    uart_send(RESP_CAL_DONE);
    repeat (2 * B) @(negedge clk);
    check_eq("rdy_count_a5", rdy_pulses - rbase, 1);
    check_eq("resp_hold_a5", resp, RESP_CAL_DONE);
    check_eq("rxq_drained_a5", rx_q.size(), 0);

    rbase = rdy_pulses;
    base = snt_cycles;
    fork
      send_cmd(16'h5AF0, lat);
      uart_send(8'h3C);
    join
    repeat (3 * B) @(negedge clk);
    check_eq("duplex_latency", (lat >= 20 * B + 2) && (lat <= 20 * B + 4), 1);
    check_eq("duplex_snt", snt_cycles - base, 1);
    check_eq("duplex_rdy", rdy_pulses - rbase, 1);
    check_eq("duplex_resp", resp, 8'h3C);

    base = snt_cycles;
    fork
      send_cmd(16'hBEEF, lat);
      begin
        repeat (3 * B) @(negedge clk);
        cmd = 16'h1234;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
      end
    join
    repeat (25 * B) @(negedge clk);
    check_eq("busy_snd_one_snt", snt_cycles - base, 1);
    check_eq("busy_snd_txq", tx_q.size(), 0);

    base = snt_cycles;
    @(negedge clk);
    cmd = 16'hC0DE;
    snd_cmd = 1'b1;
    tx_q.push_back(8'hC0);
    tx_q.push_back(8'hDE);
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (11 * B + B / 2) @(negedge clk);
    check_eq("tx_low_bit0_before_rst", TX, 0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_tx_high", TX, 1);
    repeat (3) @(negedge clk);
    check_eq("rst_mid_resp", resp, 8'h00);
    rst_n = 1'b1;
    tx_q.delete();
    repeat (25 * B) @(negedge clk);
    check_eq("rst_mid_no_snt", snt_cycles - base, 0);
    check_eq("rst_mid_tx_idle", TX, 1);

    rbase = rdy_pulses;
    @(negedge clk);
    RX = 1'b0;
    @(negedge clk);
    RX = 1'b1;
    repeat (3 * B) @(negedge clk);
    check_eq("glitch_no_rdy", rdy_pulses - rbase, 0);
    uart_send(8'h5A);
    repeat (2 * B) @(negedge clk);
    check_eq("post_glitch_rdy", rdy_pulses - rbase, 1);
    check_eq("post_glitch_resp", resp, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
